// File: rtl/score_bcd_pkg.sv
// Shared types and constants for the score/combo binary-to-BCD converter.
package score_bcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_CONV_SCORE = 2'd1,
      ST_CONV_COMBO = 2'd2,
      ST_COMMIT     = 2'd3
   } state_t;

   // Digits at or above this value get +3 before each shift
   localparam logic [3:0] ADD3_THRESH = 4'd5;

   // Width of the iteration counter for a given binary width (never below 1)
   function automatic int iter_cnt_w(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/score_bcd_converter_bcd_shift_core.sv
// bcd_shift_core: serial double-dabble converter for a single value.
// A start pulse loads the operand and performs the first iteration in the
// same edge; the remaining WIDTH-1 iterations follow one per clock, after
// which done pulses for one cycle and result holds until the next start.
module bcd_shift_core
   import score_bcd_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      operand,
   output logic                  done,
   output logic [4*DIGITS-1:0]   result
);

   localparam int SR_W  = 4*DIGITS + WIDTH;
   localparam int CNT_W = iter_cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic [SR_W-1:0]  sr_q;
   logic [SR_W-1:0]  sr_src;
   logic [SR_W-1:0]  sr_adj;
   logic [SR_W-1:0]  sr_step;
   logic [CNT_W-1:0] cnt_q;
   logic             running_q;
   logic             done_q;

   // A start iterates on the freshly loaded operand, otherwise on the register
   assign sr_src = start ? {{(4*DIGITS){1'b0}}, operand} : sr_q;

   // One iteration: 4-bit add-3 (no carry out) on digits >= 5, then shift left
   always_comb begin
      sr_adj = sr_src;
      for (int i = 0; i < DIGITS; i++) begin
         if (sr_src[WIDTH + 4*i +: 4] >= ADD3_THRESH) begin
            sr_adj[WIDTH + 4*i +: 4] = sr_src[WIDTH + 4*i +: 4] + 4'd3;
         end
      end
      sr_step = {sr_adj[SR_W-2:0], 1'b0};
   end

   // Shift register, bit counter and completion pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr_q      <= '0;
         cnt_q     <= '0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start) begin
            sr_q <= sr_step;
            if (WIDTH == 1) begin
               cnt_q     <= '0;
               running_q <= 1'b0;
               done_q    <= 1'b1;
            end else begin
               cnt_q     <= CNT_W'(1);
               running_q <= 1'b1;
            end
         end else if (running_q) begin
            sr_q  <= sr_step;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               running_q <= 1'b0;
               done_q    <= 1'b1;
            end
         end
      end
   end

   assign done   = done_q;
   assign result = sr_q[SR_W-1:WIDTH];

endmodule

// File: rtl/score_bcd_converter.sv
// score_bcd_converter: watches score/combo, converts each changed pair to
// BCD through one shared serial core (score first, then combo) and commits
// both results in the same cycle so the display never mixes sample times.
// Optional leading-zero masks are built when SCORE_BCD_BLANK_EN is defined;
// otherwise the blank ports are tied low.
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   IDLE       | compare inputs to snapshots, start on any difference
//   CONV_SCORE | core converting snap_s, result parked in hold_s
//   CONV_COMBO | core converting snap_c
//   COMMIT     | write both results, pulse done
module score_bcd_converter
   import score_bcd_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WIDTH-1:0]      score,
   input  logic [WIDTH-1:0]      combo,
   output logic [4*DIGITS-1:0]   score_bcd,
   output logic [4*DIGITS-1:0]   combo_bcd,
   output logic                  busy,
   output logic                  done,
   output logic [DIGITS-1:0]     score_blank,
   output logic [DIGITS-1:0]     combo_blank
);

   state_t state_q;
   state_t state_d;

   logic [WIDTH-1:0]    snap_s;
   logic [WIDTH-1:0]    snap_c;
   logic [4*DIGITS-1:0] hold_s;
   logic                changed;

   logic                core_start;
   logic [WIDTH-1:0]    core_operand;
   logic                core_done;
   logic [4*DIGITS-1:0] core_result;

   logic                load_snap;
   logic                hold_en;
   logic                commit;

   logic                busy_q;
   logic                done_q;

   assign changed = (score != snap_s) || (combo != snap_c);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:       if (changed)   state_d = ST_CONV_SCORE;
         ST_CONV_SCORE: if (core_done) state_d = ST_CONV_COMBO;
         ST_CONV_COMBO: if (core_done) state_d = ST_COMMIT;
         ST_COMMIT:                    state_d = ST_IDLE;
         default:                      state_d = ST_IDLE;
      endcase
   end

   // Per-state controls; the score conversion starts straight from the live
   // input so it begins in the same edge that loads the snapshots
   always_comb begin
      load_snap    = 1'b0;
      hold_en      = 1'b0;
      commit       = 1'b0;
      core_start   = 1'b0;
      core_operand = snap_c;
      case (state_q)
         ST_IDLE: begin
            load_snap    = changed;
            core_start   = changed;
            core_operand = score;
         end
         ST_CONV_SCORE: begin
            hold_en    = core_done;
            core_start = core_done;
         end
         ST_COMMIT: commit = 1'b1;
         default: ;
      endcase
   end

   bcd_shift_core #(
      .WIDTH  (WIDTH),
      .DIGITS (DIGITS)
   ) u_core (
      .clk     (clk),
      .rst     (rst),
      .start   (core_start),
      .operand (core_operand),
      .done    (core_done),
      .result  (core_result)
   );

   // Snapshots, score holding register, committed outputs and status flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         snap_s    <= '0;
         snap_c    <= '0;
         hold_s    <= '0;
         score_bcd <= '0;
         combo_bcd <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         if (load_snap) begin
            snap_s <= score;
            snap_c <= combo;
         end
         if (hold_en) hold_s <= core_result;
         if (commit) begin
            score_bcd <= hold_s;
            combo_bcd <= core_result;
         end
         busy_q <= (state_q != ST_IDLE);
         done_q <= commit;
      end
   end

   assign busy = busy_q;
   assign done = done_q;

`ifdef SCORE_BCD_BLANK_EN
   // Digit i is blank when it and every higher digit are zero; digit 0 never is
   function automatic logic [DIGITS-1:0] lead_zero_mask(input logic [4*DIGITS-1:0] bcd);
      logic [DIGITS-1:0] m;
      logic              zero_above;
      m          = '0;
      zero_above = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_above = zero_above && (bcd[4*i +: 4] == 4'd0);
         m[i]       = zero_above;
      end
      return m;
   endfunction

   // Masks update together with the digits they describe
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         score_blank <= '0;
         combo_blank <= '0;
      end else if (commit) begin
         score_blank <= lead_zero_mask(hold_s);
         combo_blank <= lead_zero_mask(core_result);
      end
   end
`else
   assign score_blank = '0;
   assign combo_blank = '0;
`endif

endmodule

// File: doc/score_bcd_converter.md
# score_bcd_converter

Serial binary-to-BCD converter between the gameplay datapath and the seven-segment decoders. It watches the datapath's 8-bit `score` and `combo` counters and converts each changed pair to three decimal digits using the shift-add-3 (double-dabble) algorithm, one bit per clock. It presents both results together, so HEX0–HEX3 show decimal rather than hex. Runs on `CLOCK_50`; the results feed the existing per-nibble `hex` decoders unchanged.

## Interface
Parameters:
- `WIDTH`, default 8: binary input width.
- `DIGITS`, default 3: BCD digits per value. Must satisfy 10^DIGITS > 2^WIDTH − 1.

Ports:
- `clk`  in  1  system clock (`CLOCK_50`).
- `rst`  in  1  reset, asynchronous, active-low.
- `score`  in  WIDTH  binary score from the datapath.
- `combo`  in  WIDTH  binary combo from the datapath.
- `score_bcd`  out  4*DIGITS  score digits, units in [3:0].
- `combo_bcd`  out  4*DIGITS  combo digits, units in [3:0].
- `busy`  out  1  high while a conversion is in flight.
- `done`  out  1  one-cycle pulse when new results are committed.
- `score_blank`  out  DIGITS  leading-zero mask for score (see Configuration).
- `combo_blank`  out  DIGITS  leading-zero mask for combo (see Configuration).

## Operation
- FSM states: IDLE, CONV_SCORE, CONV_COMBO, COMMIT.
- IDLE: each cycle, compare `score` and `combo` against the snapshot registers `snap_s` and `snap_c`.
  - If either differs, load both snapshots from the inputs and go to CONV_SCORE.
- CONV_SCORE: WIDTH iterations, bit counter running 0..WIDTH−1. Each iteration:
  - add 3 to every BCD digit that is ≥5;
  - shift the {bcd, binary} register left by 1, taking in the next MSB of `snap_s`.
  - After the last iteration, store the score result in a holding register and go to CONV_COMBO.
- CONV_COMBO: identical procedure on `snap_c`, then go to COMMIT.
- COMMIT: write both holding results to `score_bcd`/`combo_bcd` in the same cycle, pulse `done`, return to IDLE.
- Input changes during a conversion are ignored; the snapshots are not reloaded mid-conversion.
  - On return to IDLE the changed input differs from its snapshot, so a new conversion starts on the next cycle. The final value is never lost.
- Both outputs always update together. A pair from two different sample times is never shown.
- Arithmetic: the digit add-3 is 4-bit with no carry out. The shift register is 4*DIGITS+WIDTH bits.

## Timing
- Reset values: every output 0, snapshots 0, state IDLE. Inputs that are 0 after reset trigger no conversion.
- Input change visible at edge N:
  - snapshot loaded at edge N;
  - `busy` high from N+1;
  - outputs and `done` at edge N+2*WIDTH+1 (17 cycles for WIDTH=8).
- `busy` is low in IDLE only. It is high in COMMIT, the same cycle as `done`.
- Back-to-back changes: minimum spacing between commits is 2*WIDTH+2 cycles.
- Reset asserted mid-conversion: all state clears immediately, no `done`, and the outputs return to 0.
- Maximum input (255) converts to 2/5/5. No overflow exists inside the legal parameter range.

## Configuration
- `SCORE_BCD_BLANK_EN` defined:
  - at COMMIT, `score_blank[i]` / `combo_blank[i]` is set when digit i and every higher digit are 0;
  - digit 0 is never blanked, so value 0 shows a single "0".
- Not defined: both blank ports are tied to 0 and no blanking logic is built.

## Structure
- Package `score_bcd_pkg`: the state enum, the iteration-counter width constant (clog2(WIDTH)), and the add-3 threshold constant (5).
- Sub-module `bcd_shift_core`: converts a single value. Handshake:
  - `start` loads the operand;
  - `done` is high for one cycle after WIDTH iterations.
  - The top-level FSM runs it twice: score first, then combo.

## Test plan
- Reset with inputs at 0 → outputs 0, `busy`/`done` never assert over 100 cycles.
- score=8'd173, combo=8'd9 → after 17 cycles: `score_bcd`=12'h173, `combo_bcd`=12'h009, one `done` pulse.
- score=255, combo=255 → both outputs 12'h255.
- Change score 10→11 at cycle 5 of a conversion → first commit shows 10; a second conversion follows immediately and commits 11.
- Reset asserted at iteration 4 → outputs 0 and no `done`; after release, a nonzero input converts correctly.
- With `SCORE_BCD_BLANK_EN`: score=7 → `score_blank`=3'b110; score=0 → 3'b110; score=120 → 3'b000.
